character_move_scheduler: RTL
=============================

// Module: character_move_scheduler
// PURPOSE
//  Owns the x/y/direction registers for the four on-screen characters (mage, gunman, swordman, fistman; index 0..3).
//  On each movement tick, moves them one at a time in round-robin order.
//  Each character's proposed step is checked against the other three current positions (AABB overlap) and committed only if clear.
//  Sits between the keyboard key-state decode (per-character direction requests) and the sprite BRAM/pixel mux, which read the position outputs.
// PARAMETERS
//  XLIMIT  95          screen max x coordinate
//  YLIMIT  63          screen max y coordinate
//  CHAR_W  20          sprite width, pixels
//  CHAR_H  20          sprite height, pixels
//  STEP    1           pixels moved per tick
//  X0..X3  10,60,10,60 reset x of chars 0..3
//  Y0..Y3  10,10,40,40 reset y of chars 0..3
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   async active-low reset
//  move_tick     in   1   1-cycle pulse (e.g. 1 ms) starting a movement round
//  req_left      in   4   bit i = char i wants left (same for req_right/up/down)
//  req_right     in   4
//  req_up        in   4
//  req_down      in   4
//  pos_x         out  28  {x3,x2,x1,x0}, 7 b each
//  pos_y         out  24  {y3,y2,y1,y0}, 6 b each
//  dir           out  8   {d3..d0}, 2 b each: 00 up, 01 down, 10 left, 11 right
//  blocked       out  4   bit i = char i's last request was refused (collision)
//  busy          out  1   round in progress
//  round_done    out  1   1-cycle pulse at end of round
//  tick_overrun  out  1   sticky: move_tick seen while busy
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   pos = (Xi,Yi); dir=0; blocked=0; busy=0; round_done=0; tick_overrun=0; rr_ptr=0; FSM=IDLE.
//   Reset mid-round aborts the round; no round_done.
//  FSM: IDLE -> PROPOSE -> CHECK(x3) -> COMMIT -> (next char PROPOSE | DONE) -> IDLE.
//  IDLE:
//   move_tick=1 latches all req_* into shadow regs; slot=0; cur=rr_ptr; go PROPOSE.
//   req_* changes during a round are ignored.
//  PROPOSE:
//   Direction priority: L > R > U > D. Opposing keys resolve by priority.
//   No request: candidate = current, no dir change.
//   Candidate computed in 8-bit unsigned, then clamped:
//    x to [0, XLIMIT-CHAR_W] (75); y to [0, YLIMIT-CHAR_H] (43).
//    Underflow below 0 clamps to 0.
//  CHECK:
//   3 cycles, one per other char j (ascending index, skipping cur).
//   hit |= (cx < xj+W) & (cx+W > xj) & (cy < yj+H) & (cy+H > yj).
//   All sums are 8-bit; no wrap.
//   Uses committed positions, i.e. updated by earlier chars this round.
//  COMMIT:
//   If a request exists, dir[cur] updates regardless of hit.
//   hit=0: pos[cur] <= candidate; blocked[cur]=0.
//   hit=1: pos unchanged; blocked[cur]=1.
//   No request: blocked[cur]=0.
//   cur=(cur+1)%4; slot++; after slot 3 go DONE.
//  DONE:
//   round_done=1 for one cycle; rr_ptr=(rr_ptr+1)%4; go IDLE.
//  Latency:
//   Fixed 5 cycles per char whether or not it moves.
//   move_tick sampled at edge T -> round_done high in cycle T+21; busy high T+1..T+21.
//  Overrun: move_tick while busy is dropped and sets tick_overrun (cleared only by reset).
//   A tick coincident with DONE also counts as overrun.
//  Positions change only at COMMIT edges; outputs are registered.
// TESTING
//  Reset -> pos_x={60,10,60,10}, pos_y={40,40,10,10}, dir=0, busy=0; round_done 21 cycles after first tick.
//  req_left[0] with x0=0 -> x0 stays 0, dir0=10, blocked0=0.
//  req_right[0] from (54,10), char1 at (60,10):
//   candidate 55 overlaps (55<80, 75>60) -> x0=54, blocked0=1, dir0=11.
//  req_down[2] from (10,43) -> y2 stays 43 (clamp).
//  req_left[1] = req_right[1] = 1 -> left wins.
//  Two chars stepping into the same free gap:
//   rr_ptr=0 -> char0 commits, char1 blocked.
//   Next round (rr_ptr=1) char1 evaluated first.
//  Second tick 5 cycles after first -> ignored, tick_overrun=1, only one round_done.
//  reset_n low mid-CHECK -> all outputs at reset values immediately; no round_done.

Source files
------------

// File: rtl/character_move_scheduler.sv
// Round-robin movement scheduler for four sprites.
// Each step is committed only if it does not overlap another sprite.
module character_move_scheduler #(
  parameter int XLIMIT = 95,
  parameter int YLIMIT = 63,
  parameter int CHAR_W = 20,
  parameter int CHAR_H = 20,
  parameter int STEP   = 1,
  parameter int X0     = 10,
  parameter int X1     = 60,
  parameter int X2     = 10,
  parameter int X3     = 60,
  parameter int Y0     = 10,
  parameter int Y1     = 10,
  parameter int Y2     = 40,
  parameter int Y3     = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        move_tick,
  input  logic [3:0]  req_left,
  input  logic [3:0]  req_right,
  input  logic [3:0]  req_up,
  input  logic [3:0]  req_down,
  output logic [27:0] pos_x,
  output logic [23:0] pos_y,
  output logic [7:0]  dir,
  output logic [3:0]  blocked,
  output logic        busy,
  output logic        round_done,
  output logic        tick_overrun
);

  localparam int XMAX = XLIMIT - CHAR_W;
  localparam int YMAX = YLIMIT - CHAR_H;
  localparam logic [7:0] W8 = 8'(CHAR_W);
  localparam logic [7:0] H8 = 8'(CHAR_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROPOSE,
    S_CHECK,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [6:0] r_x [4];
  logic [5:0] r_y [4];
  logic [1:0] r_dir [4];
  logic [3:0] r_blk;
  logic [1:0] r_rr;
  logic [1:0] r_cur;
  logic [1:0] r_slot;
  logic [1:0] r_chk;
  logic       r_hit;
  logic [6:0] r_cx;
  logic [5:0] r_cy;
  logic       r_req;
  logic [1:0] r_ndir;
  logic       r_ovr;
  logic [3:0] r_sl;
  logic [3:0] r_sr;
  logic [3:0] r_su;
  logic [3:0] r_sd;

  logic       w_gl;
  logic       w_gr;
  logic       w_gu;
  logic       w_gd;
  logic [6:0] w_cx;
  logic [5:0] w_cy;
  logic [1:0] w_nd;
  logic       w_any;
  logic [1:0] w_j;
  logic [7:0] w_ax;
  logic [7:0] w_bx;
  logic [7:0] w_ay;
  logic [7:0] w_by;
  logic       w_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (move_tick) w_state_nxt = S_PROPOSE;
      end
      S_PROPOSE: w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (r_chk == 2'd2) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_nxt = (r_slot == 2'd3) ? S_DONE : S_PROPOSE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    round_done = (r_state == S_DONE);
  end

  // Fixed L > R > U > D priority, made one-hot before decoding
  always_comb begin
    w_gl = r_sl[r_cur];
    w_gr = r_sr[r_cur] & ~r_sl[r_cur];
    w_gu = r_su[r_cur] & ~r_sl[r_cur] & ~r_sr[r_cur];
    w_gd = r_sd[r_cur] & ~r_sl[r_cur] & ~r_sr[r_cur]
         & ~r_su[r_cur];
  end

  always_comb begin
    w_cx  = r_x[r_cur];
    w_cy  = r_y[r_cur];
    w_nd  = r_dir[r_cur];
    w_any = 1'b1;
    unique case (1'b1)
      w_gl: begin
        w_nd = 2'b10;
        w_cx = (r_x[r_cur] < 7'(STEP)) ? 7'd0
             : r_x[r_cur] - 7'(STEP);
      end
      w_gr: begin
        w_nd = 2'b11;
        w_cx = (r_x[r_cur] >= 7'(XMAX - STEP)) ? 7'(XMAX)
             : r_x[r_cur] + 7'(STEP);
      end
      w_gu: begin
        w_nd = 2'b00;
        w_cy = (r_y[r_cur] < 6'(STEP)) ? 6'd0
             : r_y[r_cur] - 6'(STEP);
      end
      w_gd: begin
        w_nd = 2'b01;
        w_cy = (r_y[r_cur] >= 6'(YMAX - STEP)) ? 6'(YMAX)
             : r_y[r_cur] + 6'(STEP);
      end
      default: w_any = 1'b0;
    endcase
  end

  // The three "other" characters in ascending order, skipping cur
  always_comb begin
    w_j   = (r_chk >= r_cur) ? 2'(r_chk + 2'd1) : r_chk;
    w_ax  = {1'b0, r_cx};
    w_bx  = {1'b0, r_x[w_j]};
    w_ay  = {2'b00, r_cy};
    w_by  = {2'b00, r_y[w_j]};
    w_hit = (w_ax < w_bx + W8) && (w_ax + W8 > w_bx)
         && (w_ay < w_by + H8) && (w_ay + H8 > w_by);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x[0]   <= 7'(X0);
      r_x[1]   <= 7'(X1);
      r_x[2]   <= 7'(X2);
      r_x[3]   <= 7'(X3);
      r_y[0]   <= 6'(Y0);
      r_y[1]   <= 6'(Y1);
      r_y[2]   <= 6'(Y2);
      r_y[3]   <= 6'(Y3);
      r_dir[0] <= 2'b00;
      r_dir[1] <= 2'b00;
      r_dir[2] <= 2'b00;
      r_dir[3] <= 2'b00;
      r_blk    <= '0;
      r_rr     <= '0;
      r_cur    <= '0;
      r_slot   <= '0;
      r_chk    <= '0;
      r_hit    <= 1'b0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_req    <= 1'b0;
      r_ndir   <= '0;
      r_ovr    <= 1'b0;
      r_sl     <= '0;
      r_sr     <= '0;
      r_su     <= '0;
      r_sd     <= '0;
    end else begin
      if (move_tick && (r_state != S_IDLE)) r_ovr <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (move_tick) begin
            r_sl   <= req_left;
            r_sr   <= req_right;
            r_su   <= req_up;
            r_sd   <= req_down;
            r_slot <= '0;
            r_cur  <= r_rr;
          end
        end
        S_PROPOSE: begin
          r_cx   <= w_cx;
          r_cy   <= w_cy;
          r_req  <= w_any;
          r_ndir <= w_nd;
          r_hit  <= 1'b0;
          r_chk  <= '0;
        end
        S_CHECK: begin
          r_hit <= r_hit | w_hit;
          r_chk <= 2'(r_chk + 2'd1);
        end
        S_COMMIT: begin
          if (r_req) r_dir[r_cur] <= r_ndir;
          if (r_req && !r_hit) begin
            r_x[r_cur] <= r_cx;
            r_y[r_cur] <= r_cy;
          end
          r_blk[r_cur] <= r_req & r_hit;
          r_cur  <= 2'(r_cur + 2'd1);
          r_slot <= 2'(r_slot + 2'd1);
        end
        S_DONE: begin
          r_rr <= 2'(r_rr + 2'd1);
        end
        default: ;
      endcase
    end
  end

  assign pos_x = {r_x[3], r_x[2], r_x[1], r_x[0]};
  assign pos_y = {r_y[3], r_y[2], r_y[1], r_y[0]};
  assign dir   = {r_dir[3], r_dir[2], r_dir[1], r_dir[0]};
  assign blocked      = r_blk;
  assign tick_overrun = r_ovr;

endmodule
